// File: rtl/tick_prescaler_if.sv
// tick_prescaler_if: configuration handshake into the tick prescaler.
//   cfg_valid   - master offers a configuration
//   cfg_ready   - slave can accept one (the shadow slot is free)
//   cfg_div     - tick period minus one
//   cfg_count   - one-shot burst length N
//   cfg_oneshot - 1 = one-shot burst, 0 = free-run
interface tick_prescaler_if #(
    parameter int DIV_WIDTH = 16,
    parameter int CNT_WIDTH = 8
);
    logic                 cfg_valid;
    logic                 cfg_ready;
    logic [DIV_WIDTH-1:0] cfg_div;
    logic [CNT_WIDTH-1:0] cfg_count;
    logic                 cfg_oneshot;
    modport master (output cfg_valid, cfg_div, cfg_count, cfg_oneshot, input cfg_ready);
    modport slave  (input cfg_valid, cfg_div, cfg_count, cfg_oneshot, output cfg_ready);
endinterface

// File: rtl/tick_prescaler.sv
// tick_prescaler: programmable clock-enable generator, one tick_en pulse every (div+1) cycles.
//   clk, reset  - clock and synchronous active-high reset
//   start, stop - begin ticking from IDLE / abort back to IDLE (stop wins)
//   cfg         - configuration handshake (slave side)
//   tick_en     - registered one-cycle enable for the downstream counter
//   busy        - high while ticking
//   done        - one-cycle pulse after the last one-shot tick
//   ticks_left  - remaining one-shot ticks, 0 in free-run
module tick_prescaler #(
    parameter int DIV_WIDTH = 16,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 stop,
    tick_prescaler_if.slave      cfg,
    output logic                 tick_en,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_WIDTH-1:0] ticks_left
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state;
    logic [DIV_WIDTH-1:0] div_reg, sh_div, phase, in_div, div_n;
    logic [CNT_WIDTH-1:0] count_reg, sh_count, in_count, cnt_n, left_n;
    logic oneshot_reg, sh_oneshot, pend, in_oneshot, os_n, last;

    assign cfg.cfg_ready = !pend;

    always_comb begin
        // Config landing in the active registers outside a tick boundary:
        // a pending shadow first, else whatever is being offered right now.
        in_div     = pend ? sh_div     : (cfg.cfg_valid ? cfg.cfg_div     : div_reg);
        in_count   = pend ? sh_count   : (cfg.cfg_valid ? cfg.cfg_count   : count_reg);
        in_oneshot = pend ? sh_oneshot : (cfg.cfg_valid ? cfg.cfg_oneshot : oneshot_reg);
        // Config in force for the period that starts after a tick.
        div_n  = pend ? sh_div     : div_reg;
        cnt_n  = pend ? sh_count   : count_reg;
        os_n   = pend ? sh_oneshot : oneshot_reg;
        // A shadow switching into one-shot restarts the burst with its own N.
        left_n = pend ? (sh_oneshot ? sh_count : '0)
                      : (oneshot_reg ? ticks_left - 1'b1 : '0);
        last   = oneshot_reg && ticks_left == CNT_WIDTH'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            tick_en     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            ticks_left  <= '0;
            div_reg     <= '0;
            count_reg   <= '0;
            oneshot_reg <= 1'b0;
            sh_div      <= '0;
            sh_count    <= '0;
            sh_oneshot  <= 1'b0;
            pend        <= 1'b0;
            phase       <= '0;
        end else begin
            tick_en <= 1'b0;
            done    <= 1'b0;
            case (state)
                IDLE: begin
                    {div_reg, count_reg, oneshot_reg} <= {in_div, in_count, in_oneshot};
                    // A config offered alongside start is the one that start uses.
                    if (start && !stop) begin
                        phase <= '0;
                        if (in_oneshot && in_count == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state      <= RUN;
                            busy       <= 1'b1;
                            tick_en    <= in_div == '0;
                            ticks_left <= in_oneshot ? in_count : '0;
                        end
                    end
                end
                RUN: begin
                    if (stop) begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        ticks_left <= '0;
                        pend       <= 1'b0;
                        {div_reg, count_reg, oneshot_reg} <= {in_div, in_count, in_oneshot};
                    end else if (tick_en) begin
                        // Period boundary: the shadow (if any) takes over here.
                        phase <= '0;
                        {div_reg, count_reg, oneshot_reg} <= {div_n, cnt_n, os_n};
                        if (pend) begin
                            pend <= 1'b0;
                        end else if (cfg.cfg_valid) begin
                            {sh_div, sh_count, sh_oneshot} <= {cfg.cfg_div, cfg.cfg_count, cfg.cfg_oneshot};
                            pend <= 1'b1;
                        end
                        if (last || (os_n && left_n == '0)) begin
                            state      <= DONE;
                            busy       <= 1'b0;
                            done       <= 1'b1;
                            ticks_left <= '0;
                        end else begin
                            ticks_left <= left_n;
                            tick_en    <= div_n == '0;
                        end
                    end else begin
                        if (cfg.cfg_valid && !pend) begin
                            {sh_div, sh_count, sh_oneshot} <= {cfg.cfg_div, cfg.cfg_count, cfg.cfg_oneshot};
                            pend <= 1'b1;
                        end
                        // phase < div_reg here, so the increment never wraps.
                        phase   <= phase + 1'b1;
                        tick_en <= phase + 1'b1 == div_reg;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    pend  <= 1'b0;
                    {div_reg, count_reg, oneshot_reg} <= {in_div, in_count, in_oneshot};
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tick_prescaler.sv
// tb_tick_prescaler: scoreboard bench for tick_prescaler against a tick-schedule model.
module tb_tick_prescaler;
    logic       clk = 1'b0;
    logic       reset, start, stop;
    logic       tick_en, busy, done;
    logic [7:0] ticks_left;

    tick_prescaler_if #(.DIV_WIDTH(16), .CNT_WIDTH(8)) cif ();

    tick_prescaler #(.DIV_WIDTH(16), .CNT_WIDTH(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .stop       (stop),
        .cfg        (cif),
        .tick_en    (tick_en),
        .busy       (busy),
        .done       (done),
        .ticks_left (ticks_left)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        bit is_done;
        int left;
    } ev_t;

    ev_t q[$];
    ev_t e;
    int  tests = 0, fails = 0, cyc = 0;
    bit  armed = 0;

    // Model: state 0 idle / 1 run / 2 done; ticks are scheduled as absolute cycle numbers.
    int mst, mdiv, mcnt, sdiv, scnt, next_tick, mleft;
    bit mos, sos, mpend;
    bit exp_busy, exp_ready;
    int exp_left;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic apply_shadow();
        mdiv = sdiv; mcnt = scnt; mos = sos; mpend = 0;
    endtask

    task automatic model_edge(input bit r, s, p, v, input int d, n, input bit o);
        bit last;
        int nl;
        if (r) begin
            mst = 0; mdiv = 0; mcnt = 0; mos = 0; sdiv = 0; scnt = 0; sos = 0;
            mpend = 0; mleft = 0;
            return;
        end
        case (mst)
            0: begin
                if (v) begin mdiv = d; mcnt = n; mos = o; end
                if (s && !p) begin
                    if (mos && mcnt == 0) mst = 2;
                    else begin
                        mst = 1;
                        next_tick = cyc + 1 + mdiv;
                        mleft = mos ? mcnt : 0;
                    end
                end
            end
            1: begin
                if (p) begin
                    mst = 0; mleft = 0;
                    if (mpend) apply_shadow();
                    else if (v) begin mdiv = d; mcnt = n; mos = o; end
                end else if (cyc == next_tick) begin
                    last = mos && mleft == 1;
                    if (mpend) begin
                        apply_shadow();
                        nl = mos ? mcnt : 0;
                    end else begin
                        if (v) begin sdiv = d; scnt = n; sos = o; mpend = 1; end
                        nl = mos ? mleft - 1 : 0;
                    end
                    if (last || (mos && nl == 0)) begin
                        mst = 2; mleft = 0;
                    end else begin
                        mleft = nl;
                        next_tick = cyc + 1 + mdiv;
                    end
                end else if (v && !mpend) begin
                    sdiv = d; scnt = n; sos = o; mpend = 1;
                end
            end
            default: begin
                mst = 0;
                if (mpend) apply_shadow();
                else if (v) begin mdiv = d; mcnt = n; mos = o; end
            end
        endcase
    endtask

    // One clock cycle: publish expectations for this cycle, drive inputs, advance the model.
    task automatic step(input bit r, s, p, v, input int d, n, input bit o);
        if (mst == 1 && cyc == next_tick) q.push_back('{cyc, 1'b0, mleft});
        if (mst == 2) q.push_back('{cyc, 1'b1, 0});
        exp_busy  = mst == 1;
        exp_ready = !mpend;
        exp_left  = mleft;
        reset = r; start = s; stop = p;
        cif.cfg_valid   = v;
        cif.cfg_div     = d[15:0];
        cif.cfg_count   = n[7:0];
        cif.cfg_oneshot = o;
        model_edge(r, s, p, v, d, n, o);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic nop(input int k);
        repeat (k) step(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic cfg(input int d, n, input bit o);
        step(0, 0, 0, 1, d, n, o);
    endtask

    task automatic strt();
        step(0, 1, 0, 0, 0, 0, 0);
    endtask

    task automatic stp();
        step(0, 0, 1, 0, 0, 0, 0);
    endtask

    // Monitor: per-cycle status checks plus scoreboard pops on every tick_en/done.
    initial begin
        forever begin
            @(negedge clk);
            if (armed) begin
                check("busy", busy, exp_busy);
                check("cfg_ready", cif.cfg_ready, exp_ready);
                check("ticks_left", ticks_left, exp_left);
                while (q.size() > 0 && q[0].cyc < cyc) begin
                    tests++;
                    fails++;
                    $display("FAIL missing_event: expected %s at cycle %0d, got none",
                             q[0].is_done ? "done" : "tick_en", q[0].cyc);
                    void'(q.pop_front());
                end
                if (tick_en || done) begin
                    if (q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_event at cycle %0d: got tick_en=%0b done=%0b, expected neither",
                                 cyc, tick_en, done);
                    end else begin
                        e = q.pop_front();
                        check("event_cycle", cyc, e.cyc);
                        check("event_done", done, e.is_done);
                        check("event_tick", tick_en, !e.is_done);
                        check("event_left", ticks_left, e.left);
                    end
                end
            end
        end
    end

    initial begin
        reset = 1; start = 0; stop = 0;
        cif.cfg_valid = 0; cif.cfg_div = '0; cif.cfg_count = '0; cif.cfg_oneshot = 0;
        @(posedge clk);
        #1;
        cyc = 1;
        model_edge(1, 0, 0, 0, 0, 0, 0);
        armed = 1;
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        // free-run div=3
        cfg(3, 0, 0); strt(); nop(17); stp(); nop(2);
        // one-shot div=1 N=3, then N=0
        cfg(1, 3, 1); strt(); nop(10);
        cfg(0, 0, 1); strt(); nop(3);
        // div=0 ticks every cycle
        cfg(0, 0, 0); strt(); nop(5); stp(); nop(2);
        // runtime reconfiguration div=4 -> div=1
        cfg(4, 0, 0); strt(); nop(2); cfg(1, 0, 0); nop(12); stp(); nop(2);
        // start+stop together in IDLE
        cfg(2, 0, 0); step(0, 1, 1, 0, 0, 0, 0); nop(3);
        // stop on the tick cycle
        cfg(3, 0, 0); strt(); nop(3); stp(); nop(3);
        // start during RUN is ignored
        strt(); nop(2); strt(); nop(8); stp(); nop(1);
        // reset for 3 cycles mid one-shot run
        cfg(2, 5, 1); strt(); nop(4);
        repeat (3) step(1, 0, 0, 0, 0, 0, 0);
        nop(3);
        // randomized traffic
        for (int i = 0; i < 6000; i++) begin
            int r;
            r = $urandom_range(0, 999);
            step(r < 4, $urandom_range(0, 7) == 0, $urandom_range(0, 39) == 0,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 9), $urandom_range(0, 5),
                 1'($urandom_range(0, 1)));
        end
        // maximum period, one tick
        stp(); nop(2);
        cfg(16'hFFFF, 1, 1); strt(); nop(65540);
        nop(3);
        check("scoreboard_empty", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
